// File: rtl/wdt_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg
// Shared definitions for the watchdog kick generator and any logic that
// monitors it (for example, decoding o_state).
//   wdt_state_e : FSM state encoding (IDLE=0, START=1, RUN=2, HOLD=3)
//   MISS_MAX    : saturation value of the consecutive-miss counter
// -----------------------------------------------------------------------------
package wdt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_HOLD  = 2'd3
   } wdt_state_e;

   localparam logic [7:0] MISS_MAX = 8'hFF;

endpackage

// File: rtl/wdt_tick_prescaler.sv
// -----------------------------------------------------------------------------
// wdt_tick_prescaler
// Divides clk by CLK_DIV. Produces a one-cycle internal tick at the last
// prescaler count, and a registered counter clock with exactly one rising
// edge per tick.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   run     : count enable; when low the prescaler and cnt_clk are held at 0
//   tick    : high for the cycle where the prescaler equals CLK_DIV-1
//   cnt_clk : registered counter clock, high for the upper half of the count
// -----------------------------------------------------------------------------
module wdt_tick_prescaler #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick,
   output logic cnt_clk
);

   localparam int             PW     = $clog2(CLK_DIV);
   localparam logic [PW-1:0]  P_MAX  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0]  P_HALF = PW'(CLK_DIV / 2);

   logic [PW-1:0] p_q, p_d;
   logic          cnt_clk_q, cnt_clk_d;

   always_comb begin
      p_d       = '0;
      cnt_clk_d = 1'b0;
      if (run) begin
         p_d       = (p_q == P_MAX) ? '0 : p_q + PW'(1);
         cnt_clk_d = (p_q >= P_HALF);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q       <= '0;
         cnt_clk_q <= 1'b0;
      end else begin
         p_q       <= p_d;
         cnt_clk_q <= cnt_clk_d;
      end
   end

   // Gated with run so that no tick is seen on the cycle the generator is
   // being disabled.
   assign tick    = run && (p_q == P_MAX);
   assign cnt_clk = cnt_clk_q;

endmodule

// File: rtl/wdt_kick_gen.sv
// -----------------------------------------------------------------------------
// wdt_kick_gen
// Feeds the board watchdog counter: a counter clock (one rising edge per tick)
// and a periodic clear pulse issued only while the monitored function is
// healthy. On a watchdog timeout it backs off for HOLDOFF ticks and restarts.
//   i_clk         : system clock
//   i_rst_n       : asynchronous active-low reset
//   i_en          : generator enable (level); low forces IDLE
//   i_healthy     : health flag, sampled at kick slots
//   i_wdt_timeout : watchdog timeout flag (level), honoured in RUN
//   o_cnt_clk     : watchdog counter clock, registered
//   o_kick        : watchdog clear pulse, registered, KICK_WIDTH cycles wide
//   o_state       : current FSM state (wdt_pkg encoding)
//   o_miss_cnt    : consecutive unhealthy kick slots, saturating at MISS_MAX
// -----------------------------------------------------------------------------
module wdt_kick_gen
   import wdt_pkg::*;
#(
   parameter int CLK_DIV     = 16,
   parameter int KICK_PERIOD = 3,
   parameter int KICK_WIDTH  = 2,
   parameter int START_DLY   = 2,
   parameter int HOLDOFF     = 5,
   parameter int CNT_W       = 10
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic       i_healthy,
   input  logic       i_wdt_timeout,
   output logic       o_cnt_clk,
   output logic       o_kick,
   output logic [1:0] o_state,
   output logic [7:0] o_miss_cnt
);

   localparam int               KW_W       = $clog2(KICK_WIDTH + 1);
   localparam logic [KW_W-1:0]  KW_INIT    = KW_W'(KICK_WIDTH - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);
   localparam logic [CNT_W-1:0] KICK_LAST  = CNT_W'(KICK_PERIOD - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);

   wdt_state_e       state_q, state_d;
   // START, RUN and HOLD each use their own tick count but never at the same
   // time, so one counter cleared on every state change serves all three.
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KW_W-1:0]  kw_q, kw_d;
   logic             kick_q, kick_d;
   logic [7:0]       miss_q, miss_d;
   logic             slot;
   logic             tick;
   logic             presc_run;

   // Prescaler stops in IDLE and on the cycle i_en drops, so o_cnt_clk is
   // already 0 on the first IDLE cycle and p is 0 on the first START cycle.
   assign presc_run = i_en && (state_q != ST_IDLE);

   wdt_tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_presc (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .run     (presc_run),
      .tick    (tick),
      .cnt_clk (o_cnt_clk)
   );

   // Next state, tick counter and kick-slot detection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      slot    = 1'b0;
      if (!i_en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_START;
               cnt_d   = '0;
            end
            ST_START: begin
               if (tick) begin
                  if (cnt_q == START_LAST) begin
                     slot    = 1'b1;
                     state_d = ST_RUN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_RUN: begin
               // Timeout beats a coincident slot: no pulse, miss count untouched.
               if (i_wdt_timeout) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end else if (tick) begin
                  if (cnt_q == KICK_LAST) begin
                     slot  = 1'b1;
                     cnt_d = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  if (cnt_q == HOLD_LAST) begin
                     state_d = ST_START;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Kick pulse width and miss counter.
   always_comb begin
      kick_d = 1'b0;
      kw_d   = kw_q;
      miss_d = miss_q;
      if (slot) begin
         if (i_healthy) begin
            kick_d = 1'b1;
            kw_d   = KW_INIT;
            miss_d = '0;
         end else if (miss_q != MISS_MAX) begin
            miss_d = miss_q + 8'd1;
         end
      end else if (kick_q && (kw_q != '0)) begin
         kick_d = 1'b1;
         kw_d   = kw_q - KW_W'(1);
      end
      // Any exit from RUN cuts an in-flight pulse on the same edge.
      if (state_d != ST_RUN) begin
         kick_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         kw_q    <= '0;
         kick_q  <= 1'b0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kw_q    <= kw_d;
         kick_q  <= kick_d;
         miss_q  <= miss_d;
      end
   end

   assign o_kick     = kick_q;
   assign o_state    = state_q;
   assign o_miss_cnt = miss_q;

endmodule

// File: tb/tb_wdt_kick_gen.sv
// -----------------------------------------------------------------------------
// tb_wdt_kick_gen
// Self-checking bench for wdt_kick_gen with CLK_DIV=4, KICK_PERIOD=3,
// KICK_WIDTH=2, START_DLY=2, HOLDOFF=5. Edge k is the k-th rising clock edge
// after the edge that moves IDLE to START; outputs are sampled 1 time unit
// after each edge.
// -----------------------------------------------------------------------------
module tb_wdt_kick_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       healthy;
   logic       wdt_to;
   logic       cnt_clk;
   logic       kick;
   logic [1:0] state;
   logic [7:0] miss;

   int n_chk;
   int n_fail;

   wdt_kick_gen #(
      .CLK_DIV     (4),
      .KICK_PERIOD (3),
      .KICK_WIDTH  (2),
      .START_DLY   (2),
      .HOLDOFF     (5),
      .CNT_W       (10)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_en          (en),
      .i_healthy     (healthy),
      .i_wdt_timeout (wdt_to),
      .o_cnt_clk     (cnt_clk),
      .o_kick        (kick),
      .o_state       (state),
      .o_miss_cnt    (miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       healthy;
      logic       timeout;
      logic [1:0] st;
      logic       kick;
      logic       cc;
      logic [7:0] miss;
   } vec_t;

   vec_t vecs[24];

   // Loopback watchdog model state.
   int   wd_cnt;
   int   wd_max;
   int   kicks;
   logic cc_prev;
   logic kick_prev;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0d at %0t", name, act, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Watchdog counter: counts rising edges of o_cnt_clk, cleared by o_kick,
   // times out at 6. Once the generator is in HOLD the board is assumed to
   // have reset the watchdog, so the model clears itself.
   task automatic lb_step();
      step(1);
      if (state == 2'd3) begin
         wd_cnt = 0;
         wdt_to = 1'b0;
      end else begin
         if (cnt_clk && !cc_prev) wd_cnt++;
         if (kick) wd_cnt = 0;
         if (wd_cnt > wd_max) wd_max = wd_cnt;
         if (wd_cnt >= 6) wdt_to = 1'b1;
      end
      if (kick && !kick_prev) kicks++;
      cc_prev   = cnt_clk;
      kick_prev = kick;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bit seen;
      n_chk   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      healthy = 1'b0;
      wdt_to  = 1'b0;
      #1;
      chk("reset_state", int'(state), 0);
      chk("reset_kick", int'(kick), 0);
      chk("reset_cnt_clk", int'(cnt_clk), 0);
      chk("reset_miss", int'(miss), 0);
      step(2);
      rst_n = 1'b1;
      step(2);
      chk("idle_state_en0", int'(state), 0);

      // Start-up and first RUN period, all healthy. Vector k is applied before
      // edge k and checked after it.
      for (int k = 0; k < 24; k++) begin
         vecs[k].en      = 1'b1;
         vecs[k].healthy = 1'b1;
         vecs[k].timeout = 1'b0;
         vecs[k].st      = (k < 8) ? 2'd1 : 2'd2;
         vecs[k].kick    = (k == 8 || k == 9 || k == 20 || k == 21);
         vecs[k].cc      = (k >= 3) && ((k % 4 == 3) || (k % 4 == 0));
         vecs[k].miss    = 8'd0;
      end
      for (int k = 0; k < 24; k++) begin
         en      = vecs[k].en;
         healthy = vecs[k].healthy;
         wdt_to  = vecs[k].timeout;
         step(1);
         chk($sformatf("vec%0d_state", k), int'(state), int'(vecs[k].st));
         chk($sformatf("vec%0d_kick", k), int'(kick), int'(vecs[k].kick));
         chk($sformatf("vec%0d_cnt_clk", k), int'(cnt_clk), int'(vecs[k].cc));
         chk($sformatf("vec%0d_miss", k), int'(miss), int'(vecs[k].miss));
      end

      // Unhealthy slot at edge 32, healthy slot at edge 44.
      healthy = 1'b0;
      step(9);
      chk("miss_slot_kick", int'(kick), 0);
      chk("miss_slot_cnt", int'(miss), 1);
      healthy = 1'b1;
      step(1);
      chk("miss_slot_kick_next", int'(kick), 0);
      step(11);
      chk("recover_kick", int'(kick), 1);
      chk("recover_miss", int'(miss), 0);

      // 300 unhealthy slots: 254 after 254, saturate at 255.
      healthy = 1'b0;
      step(3048);
      chk("miss_254", int'(miss), 254);
      step(12);
      chk("miss_255", int'(miss), 255);
      step(540);
      chk("miss_saturated", int'(miss), 255);
      healthy = 1'b1;
      step(12);
      chk("sat_recover_kick", int'(kick), 1);
      chk("sat_recover_miss", int'(miss), 0);
      step(2);
      chk("pulse_width_end", int'(kick), 0);

      // Timeout in RUN -> HOLD for 5 ticks (17 cycles at this phase) -> START.
      wdt_to = 1'b1;
      step(1);
      chk("timeout_to_hold", int'(state), 3);
      wdt_to = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk($sformatf("hold_quiet%0d", i), int'({state, kick}), int'({2'd3, 1'b0}));
      end
      step(1);
      chk("hold_to_start", int'(state), 1);
      step(7);
      chk("restart_kick_early", int'(kick), 0);
      step(1);
      chk("restart_kick_rise", int'(kick), 1);
      chk("restart_state_run", int'(state), 2);

      // Disable during the kick high cycle.
      en = 1'b0;
      step(1);
      chk("dis_kick", int'(kick), 0);
      chk("dis_cnt_clk", int'(cnt_clk), 0);
      chk("dis_state", int'(state), 0);

      // Unhealthy first slot, then timeout coincident with the next slot.
      en      = 1'b1;
      healthy = 1'b0;
      step(1);
      chk("reen_state", int'(state), 1);
      step(8);
      chk("start_slot_state", int'(state), 2);
      chk("start_slot_kick", int'(kick), 0);
      chk("start_slot_miss", int'(miss), 1);
      healthy = 1'b1;
      step(11);
      chk("pre_coinc_kick", int'(kick), 0);
      wdt_to = 1'b1;
      step(1);
      chk("coinc_state", int'(state), 3);
      chk("coinc_kick", int'(kick), 0);
      chk("coinc_miss", int'(miss), 1);
      wdt_to = 1'b0;
      step(1);
      chk("coinc_kick_next", int'(kick), 0);
      en = 1'b0;
      step(1);
      chk("idle_keeps_miss_state", int'(state), 0);
      chk("idle_keeps_miss", int'(miss), 1);

      // Asynchronous reset mid-run.
      en      = 1'b1;
      healthy = 1'b0;
      step(10);
      chk("prerst_state", int'(state), 2);
      chk("prerst_miss", int'(miss), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_kick", int'(kick), 0);
      chk("async_rst_cnt_clk", int'(cnt_clk), 0);
      chk("async_rst_miss", int'(miss), 0);
      en = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(4);
      chk("post_rst_idle", int'({state, kick, cnt_clk}), 0);

      // Loopback with a 6-tick watchdog, healthy.
      wd_cnt    = 0;
      wd_max    = 0;
      kicks     = 0;
      cc_prev   = 1'b0;
      kick_prev = 1'b0;
      en        = 1'b1;
      healthy   = 1'b1;
      seen      = 1'b0;
      for (int i = 0; i < 200; i++) begin
         lb_step();
         if (wdt_to) seen = 1'b1;
      end
      chk("lb_healthy_no_timeout", int'(seen), 0);
      chk("lb_healthy_kicks", kicks, 16);

      // Unhealthy: watchdog times out after 6 ticks, generator holds, restarts.
      healthy = 1'b0;
      wd_max  = 0;
      seen    = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         lb_step();
         if (state == 2'd3) seen = 1'b1;
      end
      chk("lb_hold_reached", int'(seen), 1);
      chk("lb_ticks_to_timeout", wd_max, 6);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         lb_step();
         if (state == 2'd1) seen = 1'b1;
      end
      chk("lb_restart", int'(seen), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
